// File: rtl/tex_pkg.sv
// Shared texture-memory definitions: write-sequencer states, byte payload, BRAM geometry.
package tex_pkg;

  localparam int unsigned TEX_ADDR_W   = 13;
  localparam int unsigned TEX_NUM_BRAM = 8;
  localparam logic [7:0]  TEX_BRAM_CFG = 8'b00100101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_ADVANCE = 2'd3
  } tex_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tex_byte_t;

  // One-hot write strobe for the BRAM selected by the top three address bits.
  function automatic logic [TEX_NUM_BRAM-1:0] bank_onehot(input logic [2:0] bank);
    bank_onehot       = '0;
    bank_onehot[bank] = 1'b1;
  endfunction

endpackage

// File: rtl/tex_write_ctrl_if.sv
// Host-loader stream, write-pointer control and BRAM write bus of tex_write_ctrl.
// Carries the optional csum output when TEX_WRITE_CSUM_EN is defined.
interface tex_write_ctrl_if
  import tex_pkg::*;
#(
  parameter int unsigned ADDR_W = TEX_ADDR_W
) ();

  logic                    start;
  logic [ADDR_W-1:0]       start_addr;
  logic                    blank;
  logic                    s_valid;
  logic                    s_ready;
  logic [7:0]              s_data;
  logic                    s_last;
  logic [7:0]              waddr;
  logic [1:0]              wsel;
  logic [7:0]              wdata;
  logic [TEX_NUM_BRAM-1:0] strobe;
  logic                    busy;
  logic                    done;
  logic                    wrapped;
`ifdef TEX_WRITE_CSUM_EN
  logic [7:0]              csum;

  modport master (
    output start, start_addr, blank, s_valid, s_data, s_last,
    input  s_ready, waddr, wsel, wdata, strobe, busy, done, wrapped, csum
  );

  modport slave (
    input  start, start_addr, blank, s_valid, s_data, s_last,
    output s_ready, waddr, wsel, wdata, strobe, busy, done, wrapped, csum
  );
`else
  modport master (
    output start, start_addr, blank, s_valid, s_data, s_last,
    input  s_ready, waddr, wsel, wdata, strobe, busy, done, wrapped
  );

  modport slave (
    input  start, start_addr, blank, s_valid, s_data, s_last,
    output s_ready, waddr, wsel, wdata, strobe, busy, done, wrapped
  );
`endif

endinterface

// File: rtl/tex_write_ctrl.sv
// Blanking-gated write sequencer: one stream byte -> strobe / hold / advance on the texture BRAMs.
// Optional running byte checksum output enabled by TEX_WRITE_CSUM_EN.
module tex_write_ctrl
  import tex_pkg::*;
#(
  parameter int unsigned ADDR_W        = TEX_ADDR_W,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tex_write_ctrl_if.slave  bus
);

  localparam int unsigned CNT_MAX = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  tex_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  tex_byte_t               wbyte_q, wbyte_d;
  logic [TEX_NUM_BRAM-1:0] strobe_q, strobe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wrapped_q, wrapped_d;
  logic                    s_ready_c;
  logic                    accept_c;
`ifdef TEX_WRITE_CSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  // Ready depends only on state, blank and reset: never on s_valid.
  assign s_ready_c = rst_n && bus.blank && (state_q == ST_IDLE);
  assign accept_c  = s_ready_c && bus.s_valid;

  // Next-state, pointer and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    wbyte_d   = wbyte_q;
    wrapped_d = wrapped_q;
`ifdef TEX_WRITE_CSUM_EN
    csum_d    = csum_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ptr_d     = bus.start_addr;
          wrapped_d = 1'b0;
`ifdef TEX_WRITE_CSUM_EN
          csum_d    = 8'h00;
`endif
        end
        if (accept_c) begin
          wbyte_d.data = bus.s_data;
          wbyte_d.last = bus.s_last;
          cnt_d        = '0;
          state_d      = ST_STROBE;
`ifdef TEX_WRITE_CSUM_EN
          csum_d       = 8'(csum_d + bus.s_data);
`endif
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_ADVANCE;
        end else begin
          cnt_d   = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_ADVANCE: begin
        ptr_d = ADDR_W'(ptr_q + 1'b1);
        if (&ptr_q) begin
          wrapped_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they align with it.
    strobe_d = (state_d == ST_STROBE) ? bank_onehot(ptr_d[ADDR_W-1 -: 3]) : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_ADVANCE) && wbyte_d.last;
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wbyte_q   <= '0;
      strobe_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
`ifdef TEX_WRITE_CSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wbyte_q   <= wbyte_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
`ifdef TEX_WRITE_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.waddr   = ptr_q[7:0];
  assign bus.wsel    = ptr_q[9:8];
  assign bus.wdata   = wbyte_q.data;
  assign bus.strobe  = strobe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wrapped = wrapped_q;
`ifdef TEX_WRITE_CSUM_EN
  assign bus.csum    = csum_q;
`endif

endmodule
